// File: rtl/alu_rr_sched.sv
// alu_rr_sched: round-robin scheduler sharing one W-bit ALU between two
// requesters. The winning requester's opcode and operands are latched in
// IDLE, the operation is evaluated in EXEC, and the registered result is
// presented with a done pulse in DONE. Every operation takes three cycles.
//
// Optional feature: define ALU_RR_SCHED_STATS_EN to build saturating 8-bit
// grant counters on cnt_0/cnt_1. Without it, both counters are tied to 0.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ena                 allows new grants (an operation already granted completes)
//   req_x/op_x/a_x/b_x  requester x: level request, opcode, operands (x = 0, 1)
//   gnt_x, done_x       one-cycle grant (EXEC) and completion (DONE) pulses
//   result/carry/zero   registered ALU result and flags, held until the next update
//   err                 illegal opcode flag for the last operation
//   busy                high whenever the FSM is outside IDLE
//   cnt_0, cnt_1        grant counters (feature build only, 0 otherwise)

module alu_rr_sched #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ena,
   input  logic         req_0,
   input  logic [2:0]   op_0,
   input  logic [W-1:0] a_0,
   input  logic [W-1:0] b_0,
   input  logic         req_1,
   input  logic [2:0]   op_1,
   input  logic [W-1:0] a_1,
   input  logic [W-1:0] b_1,
   output logic         gnt_0,
   output logic         gnt_1,
   output logic         done_0,
   output logic         done_1,
   output logic [W-1:0] result,
   output logic         carry,
   output logic         zero,
   output logic         err,
   output logic         busy,
   output logic [7:0]   cnt_0,
   output logic [7:0]   cnt_1
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t       state;
   logic         last;
   logic         owner;
   logic [2:0]   op_q;
   logic [W-1:0] a_q;
   logic [W-1:0] b_q;

   logic         win_valid;
   logic         win;
   logic         grant_now;
   logic [W+1:0] alu_out;   // {err, carry, result}

   // ALU evaluation; returns {err, carry, result}.
   function automatic logic [W+1:0] alu_calc(input logic [2:0]   op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
      logic [W:0]   wide;
      logic [W-1:0] res;
      logic         c;
      logic         e;
      wide = '0;
      res  = '0;
      c    = 1'b0;
      e    = 1'b0;
      case (op)
         3'd0: begin
            wide = {1'b0, a} + {1'b0, b};
            res  = wide[W-1:0];
            c    = wide[W];
         end
         3'd1: begin
            // The extra MSB of the widened difference is the borrow (a < b).
            wide = {1'b0, a} - {1'b0, b};
            res  = wide[W-1:0];
            c    = wide[W];
         end
         3'd2: res = a & b;
         3'd3: res = a | b;
         3'd4: begin
            res = {a[W-2:0], 1'b0};
            c   = a[W-1];
         end
         3'd5: begin
            res = {1'b0, a[W-1:1]};
            c   = a[0];
         end
         default: e = 1'b1;
      endcase
      return {e, c, res};
   endfunction

   // Arbitration: a lone request wins; with both high, the port not served last wins.
   always_comb begin
      win_valid = ena & (req_0 | req_1);
      win       = 1'b0;
      if (req_0 && req_1) begin
         win = ~last;
      end else if (req_1) begin
         win = 1'b1;
      end
   end

   assign grant_now = (state == IDLE) && win_valid;
   assign alu_out   = alu_calc(op_q, a_q, b_q);

   // Operand capture: pure data, no reset needed.
   always_ff @(posedge clk) begin
      if (grant_now) begin
         op_q <= win ? op_1 : op_0;
         a_q  <= win ? a_1  : a_0;
         b_q  <= win ? b_1  : b_0;
      end
   end

   // Control FSM with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         last   <= 1'b1;
         owner  <= 1'b0;
         gnt_0  <= 1'b0;
         gnt_1  <= 1'b0;
         done_0 <= 1'b0;
         done_1 <= 1'b0;
         result <= '0;
         carry  <= 1'b0;
         zero   <= 1'b0;
         err    <= 1'b0;
         busy   <= 1'b0;
      end else begin
         gnt_0  <= 1'b0;
         gnt_1  <= 1'b0;
         done_0 <= 1'b0;
         done_1 <= 1'b0;
         case (state)
            IDLE: begin
               if (win_valid) begin
                  owner <= win;
                  last  <= win;
                  gnt_0 <= ~win;
                  gnt_1 <= win;
                  busy  <= 1'b1;
                  state <= EXEC;
               end
            end
            EXEC: begin
               result <= alu_out[W-1:0];
               carry  <= alu_out[W];
               err    <= alu_out[W+1];
               zero   <= (alu_out[W-1:0] == '0);
               done_0 <= ~owner;
               done_1 <= owner;
               state  <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef ALU_RR_SCHED_STATS_EN
   // Saturating grant counters, bumped on the IDLE->EXEC edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_0 <= 8'd0;
         cnt_1 <= 8'd0;
      end else if (grant_now) begin
         if (win) begin
            if (cnt_1 != 8'hFF) cnt_1 <= cnt_1 + 8'd1;
         end else begin
            if (cnt_0 != 8'hFF) cnt_0 <= cnt_0 + 8'd1;
         end
      end
   end
`else
   assign cnt_0 = 8'd0;
   assign cnt_1 = 8'd0;
`endif

endmodule

// File: tb/tb_alu_rr_sched.sv
// Testbench for alu_rr_sched: directed vectors with hand-computed results.
// Stimulus pushes the expected completion into a scoreboard queue; a monitor
// pops and compares on every done pulse.

module tb_alu_rr_sched;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic       req_0, req_1;
   logic [2:0] op_0, op_1;
   logic [7:0] a_0, b_0, a_1, b_1;
   logic       gnt_0, gnt_1, done_0, done_1;
   logic [7:0] result;
   logic       carry, zero, err, busy;
   logic [7:0] cnt_0, cnt_1;

   alu_rr_sched #(.W(8)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .req_0  (req_0),
      .op_0   (op_0),
      .a_0    (a_0),
      .b_0    (b_0),
      .req_1  (req_1),
      .op_1   (op_1),
      .a_1    (a_1),
      .b_1    (b_1),
      .gnt_0  (gnt_0),
      .gnt_1  (gnt_1),
      .done_0 (done_0),
      .done_1 (done_1),
      .result (result),
      .carry  (carry),
      .zero   (zero),
      .err    (err),
      .busy   (busy),
      .cnt_0  (cnt_0),
      .cnt_1  (cnt_1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       port;
      logic [7:0] res;
      logic       c;
      logic       z;
      logic       e;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_cmp  = 0;
   int   n_fail = 0;
   logic pg0 = 1'b0;
   logic pg1 = 1'b0;

`ifdef ALU_RR_SCHED_STATS_EN
   localparam logic [7:0] CNT0_SAT = 8'd255;
`else
   localparam logic [7:0] CNT0_SAT = 8'd0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic p, input logic [7:0] r,
                               input logic c, input logic z, input logic e);
      exp_t x;
      x.port = p; x.res = r; x.c = c; x.z = z; x.e = e;
      return x;
   endfunction

   // Monitor: scoreboard check on every completion, plus grant sanity.
   always @(negedge clk) begin
      if (gnt_0 || gnt_1) chk("gnt_exclusive", {31'd0, gnt_0 & gnt_1}, 32'd0);
      if (done_0 || done_1) begin
         chk("done_exclusive", {31'd0, done_0 & done_1}, 32'd0);
         if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done: got done_0=%0b done_1=%0b expected no completion", done_0, done_1);
         end else begin
            mon_e = sb.pop_front();
            chk("done_port", {31'd0, done_1}, {31'd0, mon_e.port});
            chk("done_after_gnt", {31'd0, done_1 ? pg1 : pg0}, 32'd1);
            chk("result", {24'd0, result}, {24'd0, mon_e.res});
            chk("carry", {31'd0, carry}, {31'd0, mon_e.c});
            chk("zero", {31'd0, zero}, {31'd0, mon_e.z});
            chk("err", {31'd0, err}, {31'd0, mon_e.e});
         end
      end
      pg0 = gnt_0;
      pg1 = gnt_1;
   end

   task automatic raise(input int p, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      if (p == 0) begin
         req_0 = 1'b1; op_0 = op; a_0 = a; b_0 = b;
      end else begin
         req_1 = 1'b1; op_1 = op; a_1 = a; b_1 = b;
      end
   endtask

   // Waits for this port's done (bounded); scrambles the inputs once granted
   // since the DUT must work from its latched copy.
   task automatic wait_done(input int p);
      int n;
      bit got;
      n   = 0;
      got = 1'b0;
      while (!got && n < 40) begin
         @(negedge clk);
         n++;
         if (p == 0) begin
            if (gnt_0) begin a_0 = ~a_0; b_0 = ~b_0; op_0 = op_0 ^ 3'd3; end
            if (done_0) got = 1'b1;
         end else begin
            if (gnt_1) begin a_1 = ~a_1; b_1 = ~b_1; op_1 = op_1 ^ 3'd3; end
            if (done_1) got = 1'b1;
         end
      end
      chk("done_timeout", {31'd0, got}, 32'd1);
      if (p == 0) req_0 = 1'b0;
      else        req_1 = 1'b0;
   endtask

   task automatic serve(input int p, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input bit chk_lat);
      raise(p, op, a, b);
      if (chk_lat) begin
         @(posedge clk);
         #1;
         chk("gnt_latency", {31'd0, (p == 0) ? gnt_0 : gnt_1}, 32'd1);
      end
      wait_done(p);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_gnt_0"},  {31'd0, gnt_0},  32'd0);
      chk({tag, "_gnt_1"},  {31'd0, gnt_1},  32'd0);
      chk({tag, "_done_0"}, {31'd0, done_0}, 32'd0);
      chk({tag, "_done_1"}, {31'd0, done_1}, 32'd0);
      chk({tag, "_result"}, {24'd0, result}, 32'd0);
      chk({tag, "_carry"},  {31'd0, carry},  32'd0);
      chk({tag, "_zero"},   {31'd0, zero},   32'd0);
      chk({tag, "_err"},    {31'd0, err},    32'd0);
      chk({tag, "_busy"},   {31'd0, busy},   32'd0);
      chk({tag, "_cnt_0"},  {24'd0, cnt_0},  32'd0);
      chk({tag, "_cnt_1"},  {24'd0, cnt_1},  32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no end of test expected finish before 300000 ns");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; ena = 1'b1;
      req_0 = 1'b0; op_0 = 3'd0; a_0 = 8'd0; b_0 = 8'd0;
      req_1 = 1'b0; op_1 = 3'd0; a_1 = 8'd0; b_1 = 8'd0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;

      // Reset during EXEC: operation dropped, no done pulse.
      raise(0, 3'd0, 8'hF0, 8'h20);
      @(posedge clk);
      #1;
      chk("mid_exec_gnt_0", {31'd0, gnt_0}, 32'd1);
      chk("mid_exec_busy", {31'd0, busy}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("mid_exec_reset");
      req_0 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // After reset port 0 wins first; SUM with carry, then SUB to zero on port 1.
      sb.push_back(mk(1'b0, 8'h10, 1'b1, 1'b0, 1'b0));
      sb.push_back(mk(1'b1, 8'h00, 1'b0, 1'b1, 1'b0));
      fork
         serve(0, 3'd0, 8'hF0, 8'h20, 1'b1);
         serve(1, 3'd1, 8'h55, 8'h55, 1'b0);
      join

      // SUB with borrow.
      sb.push_back(mk(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0));
      serve(1, 3'd1, 8'h01, 8'h02, 1'b1);

      // Contention: order must be 0,1,0,1.
      sb.push_back(mk(1'b0, 8'h07, 1'b0, 1'b0, 1'b0));  // 03 + 04
      sb.push_back(mk(1'b1, 8'h30, 1'b0, 1'b0, 1'b0));  // F0 & 3C
      sb.push_back(mk(1'b0, 8'h3F, 1'b0, 1'b0, 1'b0));  // 0F | 30
      sb.push_back(mk(1'b1, 8'h00, 1'b1, 1'b1, 1'b0));  // 80 << 1
      fork
         begin
            serve(0, 3'd0, 8'h03, 8'h04, 1'b0);
            serve(0, 3'd3, 8'h0F, 8'h30, 1'b0);
         end
         begin
            serve(1, 3'd2, 8'hF0, 8'h3C, 1'b0);
            serve(1, 3'd4, 8'h80, 8'h11, 1'b0);
         end
      join

      // ena gating, then illegal opcode, then SHR.
      @(negedge clk);
      ena = 1'b0;
      raise(0, 3'd7, 8'h12, 8'h34);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("ena_gate_gnt", {31'd0, gnt_0}, 32'd0);
         chk("ena_gate_busy", {31'd0, busy}, 32'd0);
      end
      sb.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1));
      ena = 1'b1;
      wait_done(0);
      sb.push_back(mk(1'b0, 8'h40, 1'b1, 1'b0, 1'b0));
      serve(0, 3'd5, 8'h81, 8'h00, 1'b1);

      // Counters from a fresh reset: 300 grants to port 0.
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("stats_reset_cnt_0", {24'd0, cnt_0}, 32'd0);
      chk("stats_reset_cnt_1", {24'd0, cnt_1}, 32'd0);
      for (int i = 0; i < 300; i++) begin
         sb.push_back(mk(1'b0, 8'h02, 1'b0, 1'b0, 1'b0));
         serve(0, 3'd0, 8'h01, 8'h01, 1'b0);
      end
      @(negedge clk);
      chk("stats_cnt_0", {24'd0, cnt_0}, {24'd0, CNT0_SAT});
      chk("stats_cnt_1", {24'd0, cnt_1}, 32'd0);

      repeat (3) @(negedge clk);
      chk("queue_empty", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_rr_sched.md
Name: alu_rr_sched

Overview:
Round-robin scheduler that shares one 8-bit ALU between two requesters (port 0 and port 1).
- Arbitrates requests, latches the winner's opcode and operands, and executes one operation.
- Returns a registered result, carry and zero flags, and a one-cycle done pulse to the owner.
- Sits between the chip-level I/O sequencing logic and the ALU datapath: SUM, SUB, AND, OR, SHL, SHR.

Parameters:
- W, 8, operand/result width in bits; all arithmetic is modulo 2^W.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  low = no new grants; an operation already granted still completes
- req_0  input  1  requester 0 request, level
- op_0  input  3  requester 0 opcode
- a_0  input  W  requester 0 operand A
- b_0  input  W  requester 0 operand B
- req_1, op_1, a_1, b_1  input  1/3/W/W  same meaning, requester 1
- gnt_0, gnt_1  output  1  one-cycle grant pulse
- done_0, done_1  output  1  one-cycle completion pulse
- result  output  W  registered ALU result
- carry  output  1  carry/borrow/shifted-out bit
- zero  output  1  result == 0
- err  output  1  illegal opcode flag for the last operation
- busy  output  1  high whenever state != IDLE
- cnt_0, cnt_1  output  8  grant counters (see Optional Feature)

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; all outputs 0.
  - Round-robin pointer last=1, so requester 0 wins first.
  - An in-flight operation is dropped with no done pulse.
- FSM IDLE -> EXEC -> DONE -> IDLE:
  - Each operation takes exactly 3 cycles.
  - Maximum throughput is one operation per 3 cycles.
- IDLE:
  - If ena=1 and any req is high, choose a winner:
    - only one req high: that requester wins;
    - both high: the requester != last wins.
  - At the clock edge, for the winner:
    - latch op/a/b into internal registers;
    - set owner and last to the winner;
    - go to EXEC.
  - If ena=0 or no req is high, stay in IDLE.
- EXEC:
  - gnt_<owner>=1 for this cycle only; the requester may change its inputs from here on.
  - At the edge, compute from the latched values and register result/carry/zero/err; go to DONE.
- DONE:
  - done_<owner>=1 for this cycle only.
  - result and flags are valid here and held until the next EXEC->DONE update.
  - At the edge, go to IDLE.
- Requester protocol:
  - Hold req high until done, then drop req on the edge that ends DONE.
  - A req still high in IDLE after DONE is treated as a new request.
- Opcodes:
  - 0 SUM: result=a+b, carry=carry-out.
  - 1 SUB: result=a-b, carry=borrow (a<b unsigned).
  - 2 AND: carry=0.
  - 3 OR: carry=0.
  - 4 SHL: result=a<<1, carry=a[W-1]; b is ignored.
  - 5 SHR: result=a>>1 logical, carry=a[0]; b is ignored.
  - 6/7: result=0, carry=0, err=1, done still pulses.
  - err=0 for all legal opcodes.
- zero = (result == 0), registered together with result.
- ena falling during EXEC or DONE has no effect on that operation.
- A requester asserting req while the other is being served waits; it wins at the next IDLE if the other port is idle or was last granted.
- Starvation-free: with both reqs continuously high, grants alternate 0,1,0,1.

Optional Feature:
- Macro ALU_RR_SCHED_STATS_EN.
- Defined:
  - cnt_0/cnt_1 are 8-bit counters, incremented on the EXEC entry edge for the granted requester.
  - Counters saturate at 255 and are cleared by reset only.
- Not defined: cnt_0/cnt_1 are tied to 0 and no counter flops are synthesized.

Test Plan:
- Reset mid-EXEC:
  - req_0=1, op_0=0, a_0=8'hF0, b_0=8'h20; assert rst_n=0 during EXEC.
  - Required: no done pulse; all outputs 0; next request goes to port 0.
- Single SUM with carry:
  - req_0=1, op_0=0, a=8'hF0, b=8'h20.
  - Required: gnt_0 at cycle+1, done_0 at cycle+2, result=8'h10, carry=1, zero=0.
- SUB to zero, then SUB with borrow:
  - req_1, op=1, a=b=8'h55 -> result=0, zero=1, carry=0.
  - Then a=8'h01, b=8'h02 -> result=8'hFF, carry=1.
- Contention and fairness:
  - req_0 and req_1 held high for 4 operations.
  - Required: grant order 0,1,0,1; never gnt_0 and gnt_1 together; done_x follows gnt_x by exactly 1 cycle.
- ena gating and illegal opcode:
  - ena=0 with req_0=1: no grant for 10 cycles; busy stays 0.
  - Then ena=1, op_0=7: done_0 pulses, result=0, err=1.
  - Then op_0=5, a=8'h81: result=8'h40, carry=1, err=0.
- Stats, with ALU_RR_SCHED_STATS_EN defined:
  - 300 grants to port 0 -> cnt_0=255 (saturated), cnt_1=0.
  - Without the macro, cnt_0 and cnt_1 stay 0.
